// File: rtl/read_master.sv
// Avalon-MM read master: fetches a CSR-programmed block of samples from DDR3
// and replays it as a valid/ready stream, buffering returns in a small FIFO.
module read_master #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ddr_waitrequest,
  output logic [ADDR_W-1:0] ddr_addr,
  output logic              ddr_read,
  input  logic [DATA_W-1:0] ddr_readdata,
  input  logic              ddr_readdatavalid,
  input  logic [2:0]        csr_addr,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [15:0]       csr_writedata,
  output logic [15:0]       csr_readdata,
  output logic [DATA_W-1:0] d_out,
  output logic              v_out,
  input  logic              ready_in
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | issuing reads while words remain and credits allow
  // DRAIN | all reads issued, waiting for the stream to deliver the block
  // DONE  | block delivered, done flag set

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_step;
  logic [ADDR_W-1:0] r_wstep;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_len;
  logic [15:0]       r_wlen;
  logic [15:0]       r_issued;
  logic [15:0]       r_delivered;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic              r_read;
  logic [15:0]       r_csr_rdata;

  logic              w_soft_rst;
  logic              w_rst;
  logic              w_start;
  logic              w_active;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_credit;
  logic [15:0]       w_issued_nx;
  logic [15:0]       w_delivered_nx;
  logic [CW-1:0]     w_outstanding_nx;
  logic [CW-1:0]     w_count_nx;
  logic [15:0]       w_csr_mux;

  assign w_soft_rst = csr_write && (csr_addr == 3'd6);
  assign w_rst      = reset || w_soft_rst;
  assign w_start    = csr_write && (csr_addr == 3'd4);
  assign w_active   = (r_state == RUN) || (r_state == DRAIN);
  assign w_accept   = r_read && !ddr_waitrequest;
  // Responses outside an active block are leftovers from before a soft reset.
  assign w_push     = ddr_readdatavalid && w_active;
  assign w_pop      = v_out && ready_in;

  assign w_issued_nx      = r_issued + {15'b0, w_accept};
  assign w_delivered_nx   = r_delivered + {15'b0, w_pop};
  assign w_outstanding_nx = r_outstanding + CW'(w_accept) - CW'(w_push);
  assign w_count_nx       = r_count + CW'(w_push) - CW'(w_pop);
  // Credit is judged on post-edge occupancy so a stalled request never loses it.
  assign w_credit = ({1'b0, w_outstanding_nx} + {1'b0, w_count_nx}) < DEPTH_C;

  assign ddr_addr     = r_addr;
  assign ddr_read     = r_read;
  assign csr_readdata = r_csr_rdata;
  assign v_out        = (r_count != '0);
  assign d_out        = v_out ? r_mem[r_rd_ptr] : '0;

  always_comb begin
    w_csr_mux = 16'hDEAD;
    case (csr_addr)
      3'd0:    w_csr_mux = 16'(r_base);
      3'd1:    w_csr_mux = r_len;
      3'd2:    w_csr_mux = 16'(r_step);
      3'd3:    w_csr_mux = r_delivered;
      3'd5:    w_csr_mux = {15'b0, r_state == DONE};
      default: w_csr_mux = 16'hDEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state       <= IDLE;
      r_base        <= '0;
      r_len         <= '0;
      r_step        <= ADDR_W'(1);
      r_wstep       <= '0;
      r_wlen        <= '0;
      r_addr        <= '0;
      r_read        <= 1'b0;
      r_issued      <= '0;
      r_delivered   <= '0;
      r_outstanding <= '0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_csr_rdata   <= '0;
    end else begin
      if (csr_write) begin
        case (csr_addr)
          3'd0:    r_base <= csr_writedata[ADDR_W-1:0];
          3'd1:    r_len  <= csr_writedata;
          3'd2:    r_step <= csr_writedata[ADDR_W-1:0];
          default: ;
        endcase
      end
      if (csr_read) r_csr_rdata <= w_csr_mux;

      if (w_push) begin
        r_mem[r_wr_ptr] <= ddr_readdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count       <= w_count_nx;
      r_outstanding <= w_outstanding_nx;
      r_issued      <= w_issued_nx;
      r_delivered   <= w_delivered_nx;

      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_wlen      <= r_len;
            r_wstep     <= r_step;
            r_addr      <= r_base;
            r_issued    <= '0;
            r_delivered <= '0;
            if (r_len != 16'd0) begin
              r_state <= RUN;
              r_read  <= 1'b1;
            end else begin
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          r_read <= (w_issued_nx < r_wlen) && w_credit;
          if (w_accept) begin
            r_addr <= r_addr + r_wstep;
            if (w_issued_nx == r_wlen) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_read <= 1'b0;
          if (w_delivered_nx == r_wlen) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/read_master.md
# read_master

Avalon-MM read master that fetches a programmed block of 16-bit samples from DDR3 and replays them as a valid/ready stream into the LPC datapath. It is the DDR3 read-side counterpart of the sample-capture writer: software programs base, length and step through a small CSR slave, pulses start, then polls done. Reads are pipelined, and an internal FIFO absorbs downstream backpressure so that no `readdatavalid` word is ever lost.

## Interface
Parameters:
- `DATA_W`, 16: sample and DDR word width.
- `ADDR_W`, 16: DDR word-address width.
- `FIFO_DEPTH`, 8: output FIFO entries, power of two; also the maximum number of outstanding reads plus buffered words.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ddr_waitrequest`  in  1  slave stall.
- `ddr_addr`  out  ADDR_W  read word address.
- `ddr_read`  out  1  read request.
- `ddr_readdata`  in  DATA_W  returned word.
- `ddr_readdatavalid`  in  1  `ddr_readdata` is valid this cycle.
- `csr_addr`  in  3  CSR word address.
- `csr_read`  in  1  CSR read strobe.
- `csr_write`  in  1  CSR write strobe.
- `csr_writedata`  in  16  CSR write data.
- `csr_readdata`  out  16  CSR read data; 1-cycle latency.
- `d_out`  out  DATA_W  stream sample (signed).
- `v_out`  out  1  stream valid.
- `ready_in`  in  1  downstream ready.

## Operation
CSR map:
- 0x0 base: R/W.
- 0x1 length in words: R/W.
- 0x2 step: R/W, resets to 1.
- 0x3 delivered count: RO.
- 0x4 start: write-only pulse.
- 0x5 done: RO, bit 0.
- 0x6 soft reset: write-only pulse.
- Reads of 0x4, 0x6 and 0x7 return 16'hDEAD.
- Writes to RO addresses are ignored.

Soft reset (a write to 0x6) has exactly the same effect as `reset`.

Base, length and step are copied into working registers on start. Later CSR writes take effect only at the next start.

States:
- IDLE:
  - start with length != 0: load `ddr_addr`=base, clear issued and delivered counts, go to RUN.
  - start with length == 0: go to DONE.
- RUN:
  - Assert `ddr_read` while issued < length and (outstanding + fifo_count) < FIFO_DEPTH.
  - A request is accepted when `ddr_read` & !`ddr_waitrequest`.
  - On accept: `ddr_addr` += step (modulo 2^ADDR_W, wraps silently) and issued++.
  - While `ddr_waitrequest`=1, hold `ddr_addr` and `ddr_read` stable.
  - The accept that makes issued == length moves to DRAIN and drops `ddr_read` in the next cycle.
- DRAIN: no requests. When delivered == length, go to DONE.
- DONE: done=1. Start restarts the block exactly as from IDLE and clears done.

Start is ignored in RUN and DRAIN.

Outstanding counter:
- Increments on accept.
- Decrements on `ddr_readdatavalid`.
- Simultaneous accept and valid leave it unchanged.

Data path:
- Each `ddr_readdatavalid` word is pushed into the FIFO. The credit rule guarantees the FIFO never overflows.
- `v_out` = FIFO not empty; `d_out` = FIFO head.
- A transfer occurs when `v_out` & `ready_in`; each transfer pops one word and increments delivered.
- Push and pop in the same cycle are both honoured, including on a full or empty FIFO.
- `ddr_readdatavalid` arriving in IDLE or DONE (stale responses after a soft reset) is dropped and not counted.

## Timing
Reset values:
- `ddr_read`=0, `ddr_addr`=0, `csr_readdata`=0, `v_out`=0, `d_out`=0.
- done=0, state IDLE, FIFO empty, all counters 0.

Latency:
- Start write sampled at edge E: `ddr_read`=1 in the cycle after E.
- `ddr_readdatavalid` sampled at edge E: word visible on `d_out` with `v_out`=1 in the cycle after E.
- Last stream transfer at edge E: done reads 1 from the cycle after E.

Throughput:
- One request per cycle while `ddr_waitrequest`=0 and credits remain.
- One sample per cycle downstream while `ready_in`=1.

CSR:
- `csr_readdata` is registered; it is valid the cycle after `csr_read` and holds its value otherwise.

## Test plan
- **Basic block:** base=0x0100, length=4, step=1, zero-wait slave with 2-cycle read latency, `ready_in`=1 → addresses 0x0100–0x0103 on back-to-back cycles; 4 samples out in order; delivered=4; done=1.
- **Step and wrap:** base=0xFFFE, step=2, length=3 → addresses 0xFFFE, 0x0000, 0x0002.
- **Waitrequest:** waitrequest held high for 3 cycles on the first request → `ddr_addr` and `ddr_read` are stable throughout; no duplicate or skipped address.
- **Backpressure:** length=20, `ready_in`=0 → at most FIFO_DEPTH=8 requests issued, then `ddr_read`=0. Release `ready_in` → all 20 samples delivered in order; none lost; done=1.
- **length=0:** start → DONE the next cycle; no `ddr_read` asserted.
- **Soft reset mid-run:** write 0x6 during RUN with 3 reads outstanding → the next cycle is IDLE with `v_out`=0 and step=1; late `readdatavalid` responses are ignored; a subsequent start runs cleanly.
